fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined RV32I core. Holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction together with its PC and PC+4 into the IF/ID pipeline register for the decode stage. Applies the hazard unit's stall and flush controls and the execute stage's branch/jump redirect.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage RV32I pipeline.
// Holds the fetch PC, drives it to the combinational instruction memory and
// captures {instr, pc, pc+4, valid} into the IF/ID register for decode.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall_f         hold the fetch PC
//   stall_d         hold the IF/ID register
//   flush_d         replace IF/ID contents with a bubble (dominates stall_d)
//   pc_src_e        redirect from execute (dominates stall_f)
//   pc_target_e     redirect target; low two bits are cleared
//   pc_f            current fetch PC, drives the imem address
//   imem_rd         instruction word for pc_f (same-cycle read)
//   instr_d, pc_d, pc_plus4_d, valid_d   IF/ID register fields
//   fetch_count     instructions accepted into IF/ID (wraps)
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] pc_f,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       XLEN'(0),
    pc_plus4: XLEN'(0),
    valid:    1'b0
  };

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  ifid_t           ifid_q, ifid_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  logic [XLEN-1:0] pc_plus4_f_c;
  logic [XLEN-1:0] redirect_pc_c;
  logic            capture_c;

  // Sequential PC increment wraps naturally at 2^32
  assign pc_plus4_f_c  = pc_f_q + XLEN'(4);
  // Redirect targets are forced word-aligned
  assign redirect_pc_c = pc_target_e & ALIGN_MASK;
  // A new instruction enters IF/ID only when neither flushed nor stalled
  assign capture_c     = !flush_d && !stall_d;

  // Next fetch PC: redirect beats stall
  always_comb begin
    pc_f_d = pc_plus4_f_c;
    if (pc_src_e) begin
      pc_f_d = redirect_pc_c;
    end else if (stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  // Next IF/ID contents: flush beats stall
  always_comb begin
    ifid_d = ifid_q;
    if (flush_d) begin
      ifid_d = IFID_BUBBLE;
    end else if (!stall_d) begin
      ifid_d.instr    = imem_rd;
      ifid_d.pc       = pc_f_q;
      ifid_d.pc_plus4 = pc_plus4_f_c;
      ifid_d.valid    = 1'b1;
    end
  end

  // Accepted-instruction counter
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture_c) begin
      fetch_count_d = fetch_count_q + XLEN'(1);
    end
  end

  // State registers; reset dominates every control input
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q        <= RESET_PC_ALIGNED;
      ifid_q        <= IFID_BUBBLE;
      fetch_count_q <= XLEN'(0);
    end else begin
      pc_f_q        <= pc_f_d;
      ifid_q        <= ifid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign pc_f        = pc_f_q;
  assign instr_d     = ifid_q.instr;
  assign pc_d        = ifid_q.pc;
  assign pc_plus4_d  = ifid_q.pc_plus4;
  assign valid_d     = ifid_q.valid;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage. The driver
// queues the hand-computed post-edge state for each applied cycle; a
// monitor pops and compares one entry shortly after every rising edge.
module tb_fetch_stage;

  typedef struct {
    string       name;
    logic [31:0] pc_f;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e, pc_f, imem_rd, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h0020_81b3;
      32'h0000_000C: return 32'h0001_a103;
      32'h0000_0040: return 32'h0050_0293;
      32'h0000_0100: return 32'h0ff0_0393;
      32'hFFFF_FFFC: return 32'h00c0_0313;
      default:       return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  assign imem_rd = imem_word(pc_f);

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .pc_f        (pc_f),
    .imem_rd     (imem_rd),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .fetch_count (fetch_count)
  );

  // Monitor: compare DUT state just after each edge against the queue head
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (pc_f !== e.pc_f || instr_d !== e.instr || pc_d !== e.pc ||
          pc_plus4_d !== e.pc4 || valid_d !== e.valid || fetch_count !== e.cnt) begin
        miscompares++;
        $display("FAIL %s: got pc_f=%h instr_d=%h pc_d=%h pc_plus4_d=%h valid_d=%b cnt=%0d, want pc_f=%h instr_d=%h pc_d=%h pc_plus4_d=%h valid_d=%b cnt=%0d",
                 e.name, pc_f, instr_d, pc_d, pc_plus4_d, valid_d, fetch_count,
                 e.pc_f, e.instr, e.pc, e.pc4, e.valid, e.cnt);
      end
    end
  end

  // Apply one cycle of controls and queue the expected post-edge state
  task automatic step(input string name,
                      input logic rst, input logic sf, input logic sd,
                      input logic fd, input logic src, input logic [31:0] tgt,
                      input logic [31:0] e_pcf, input logic [31:0] e_instr,
                      input logic [31:0] e_pc, input logic [31:0] e_pc4,
                      input logic e_valid, input logic [31:0] e_cnt);
    exp_t e;
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fd;
    pc_src_e = src; pc_target_e = tgt;
    e.name = name; e.pc_f = e_pcf; e.instr = e_instr; e.pc = e_pc;
    e.pc4 = e_pc4; e.valid = e_valid; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    //    name          rst sf sd fd src target        pc_f          instr         pc_d          pc4_d         v   cnt
    step("reset",       1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0013, 32'h0,        32'h0,        0, 0);
    step("fetch0",      0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h0000_0093, 32'h0,        32'h4,        1, 1);
    step("fetch4",      0, 0, 0, 0, 0, 32'h0,        32'h8,        32'h0010_0113, 32'h4,        32'h8,        1, 2);
    step("stall1",      0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h0010_0113, 32'h4,        32'h8,        1, 2);
    step("stall2",      0, 1, 1, 0, 0, 32'h0,        32'h8,        32'h0010_0113, 32'h4,        32'h8,        1, 2);
    step("resume8",     0, 0, 0, 0, 0, 32'h0,        32'hC,        32'h0020_81b3, 32'h8,        32'hC,        1, 3);
    step("fetchC",      0, 0, 0, 0, 0, 32'h0,        32'h10,       32'h0001_a103, 32'hC,        32'h10,       1, 4);
    step("redir41",     0, 0, 0, 1, 1, 32'h41,       32'h40,       32'h0000_0013, 32'h0,        32'h0,        0, 4);
    step("fetch40",     0, 0, 0, 0, 0, 32'h0,        32'h44,       32'h0050_0293, 32'h40,       32'h44,       1, 5);
    step("redir_stall", 0, 1, 1, 1, 1, 32'h100,      32'h100,      32'h0000_0013, 32'h0,        32'h0,        0, 5);
    step("fetch100",    0, 0, 0, 0, 0, 32'h0,        32'h104,      32'h0ff0_0393, 32'h100,      32'h104,      1, 6);
    step("stallf_only", 0, 1, 0, 0, 0, 32'h0,        32'h104,      32'hDEAD_0104, 32'h104,      32'h108,      1, 7);
    step("stalld_only", 0, 0, 1, 0, 0, 32'h0,        32'h108,      32'hDEAD_0104, 32'h104,      32'h108,      1, 7);
    step("redir_top",   0, 0, 0, 1, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0013, 32'h0,     32'h0,        0, 7);
    step("wrap",        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00c0_0313, 32'hFFFF_FFFC, 32'h0,       1, 8);
    step("post_wrap0",  0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h0000_0093, 32'h0,        32'h4,        1, 9);
    step("post_wrap4",  0, 0, 0, 0, 0, 32'h0,        32'h8,        32'h0010_0113, 32'h4,        32'h8,        1, 10);
    step("mid_reset",   1, 1, 0, 0, 1, 32'h200,      32'h0,        32'h0000_0013, 32'h0,        32'h0,        0, 0);
    step("restart0",    0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h0000_0093, 32'h0,        32'h4,        1, 1);
    step("flush_only",  0, 0, 0, 1, 0, 32'h0,        32'h8,        32'h0000_0013, 32'h0,        32'h0,        0, 1);
    step("after_flush", 0, 0, 0, 0, 0, 32'h0,        32'hC,        32'h0020_81b3, 32'h8,        32'hC,        1, 2);
    step("flush_stall", 0, 0, 1, 1, 0, 32'h0,        32'h10,       32'h0000_0013, 32'h0,        32'h0,        0, 2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
